// File: rtl/pkt_gen_ctrl_if.sv
// Header handshake between the traffic scheduler (master) and one packet generator (slave).
interface pkt_gen_ctrl_if;
    logic       gen_vld;
    logic       gen_ready;
    logic [3:0] da;
    logic [2:0] prior;
    logic [9:0] len;

    modport master (output gen_vld, da, prior, len, input gen_ready);
    modport slave  (input gen_vld, da, prior, len, output gen_ready);
endinterface

// File: rtl/pkt_gen_ctrl.sv
// Traffic scheduler for one packet generator: issues fixed or LFSR-random headers with a
// programmable inter-packet gap and counts completed packets.
module pkt_gen_ctrl #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned GAP_W   = 8,
    parameter logic [9:0]  MIN_LEN = 10'd64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic [3:0]       i_cfg_da,
    input  logic [2:0]       i_cfg_prior,
    input  logic [9:0]       i_cfg_len,
    input  logic [CNT_W-1:0] i_cfg_num,
    input  logic [GAP_W-1:0] i_cfg_gap,
    pkt_gen_ctrl_if.master   gen,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pkt_cnt
);
    typedef enum logic [2:0] {StIdle, StIssue, StWaitLo, StWaitHi, StGap, StDone} state_e;

    state_e           state_q;
    logic             mode_q;
    logic [3:0]       da_q;
    logic [2:0]       prior_q;
    logic [9:0]       len_q;
    logic [CNT_W-1:0] num_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [15:0]      lfsr_q;
    logic             stop_pend_q;

    logic             hdr_mode;
    logic [15:0]      hdr_lfsr;
    logic [3:0]       hdr_da;
    logic [2:0]       hdr_prior;
    logic [9:0]       hdr_len;
    logic [9:0]       rnd_len;
    logic [3:0]       nxt_da;
    logic [2:0]       nxt_prior;
    logic [9:0]       nxt_len;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             last_pkt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // The first header of a run comes straight from the config inputs and SEED,
    // later ones from the shadow regs and the already-stepped LFSR.
    always_comb begin
        if (state_q == StIdle) begin
            hdr_mode  = i_mode;
            hdr_lfsr  = SEED;
            hdr_da    = i_cfg_da;
            hdr_prior = i_cfg_prior;
            hdr_len   = i_cfg_len;
        end else begin
            hdr_mode  = mode_q;
            hdr_lfsr  = lfsr_q;
            hdr_da    = da_q;
            hdr_prior = prior_q;
            hdr_len   = len_q;
        end
        rnd_len = {hdr_lfsr[15:8], 2'b00};
        if (rnd_len < MIN_LEN) begin
            rnd_len = MIN_LEN;
        end
        nxt_da    = hdr_mode ? hdr_lfsr[3:0] : hdr_da;
        nxt_prior = hdr_mode ? hdr_lfsr[6:4] : hdr_prior;
        nxt_len   = hdr_mode ? rnd_len : hdr_len;
        cnt_inc   = (o_pkt_cnt == '1) ? o_pkt_cnt : o_pkt_cnt + 1'b1;
        accept    = gen.gen_vld & gen.gen_ready;
        last_pkt  = stop_pend_q | i_stop | ((num_q != '0) && (cnt_inc == num_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            da_q        <= '0;
            prior_q     <= '0;
            len_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            lfsr_q      <= SEED;
            stop_pend_q <= 1'b0;
            gen.gen_vld <= 1'b0;
            gen.da      <= '0;
            gen.prior   <= '0;
            gen.len     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pkt_cnt   <= '0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        mode_q      <= i_mode;
                        da_q        <= i_cfg_da;
                        prior_q     <= i_cfg_prior;
                        len_q       <= i_cfg_len;
                        num_q       <= i_cfg_num;
                        gap_q       <= i_cfg_gap;
                        lfsr_q      <= SEED;
                        stop_pend_q <= 1'b0;
                        o_pkt_cnt   <= '0;
                        o_busy      <= 1'b1;
                        gen.gen_vld <= 1'b1;
                        gen.da      <= nxt_da;
                        gen.prior   <= nxt_prior;
                        gen.len     <= nxt_len;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    // An accept on the same edge as i_stop still counts as issued.
                    if (accept) begin
                        gen.gen_vld <= 1'b0;
                        lfsr_q      <= lfsr_step(lfsr_q);
                        stop_pend_q <= i_stop;
                        state_q     <= StWaitLo;
                    end else if (i_stop) begin
                        gen.gen_vld <= 1'b0;
                        o_done      <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StWaitLo: begin
                    if (i_stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (!gen.gen_ready) begin
                        state_q <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (gen.gen_ready) begin
                        o_pkt_cnt <= cnt_inc;
                        if (last_pkt) begin
                            o_done  <= 1'b1;
                            state_q <= StDone;
                        end else if (gap_q == '0) begin
                            gen.gen_vld <= 1'b1;
                            gen.da      <= nxt_da;
                            gen.prior   <= nxt_prior;
                            gen.len     <= nxt_len;
                            state_q     <= StIssue;
                        end else begin
                            gap_cnt_q <= gap_q;
                            state_q   <= StGap;
                        end
                    end else if (i_stop) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                StGap: begin
                    if (i_stop) begin
                        o_done  <= 1'b1;
                        state_q <= StDone;
                    end else if (gap_cnt_q == GAP_W'(1)) begin
                        gen.gen_vld <= 1'b1;
                        gen.da      <= nxt_da;
                        gen.prior   <= nxt_prior;
                        gen.len     <= nxt_len;
                        state_q     <= StIssue;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_gen_ctrl.sv
// Randomized bench for pkt_gen_ctrl: a generator model drives the handshake and a
// spec-level header/count model checks every run.
module tb_pkt_gen_ctrl;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned SEED_V = 32'hACE1;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic             i_stop;
    logic             i_mode;
    logic [3:0]       i_cfg_da;
    logic [2:0]       i_cfg_prior;
    logic [9:0]       i_cfg_len;
    logic [CNT_W-1:0] i_cfg_num;
    logic [GAP_W-1:0] i_cfg_gap;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_pkt_cnt;

    pkt_gen_ctrl_if gen_if ();

    pkt_gen_ctrl #(
        .SEED    (16'hACE1),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W),
        .MIN_LEN (10'd64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_mode      (i_mode),
        .i_cfg_da    (i_cfg_da),
        .i_cfg_prior (i_cfg_prior),
        .i_cfg_len   (i_cfg_len),
        .i_cfg_num   (i_cfg_num),
        .i_cfg_gap   (i_cfg_gap),
        .gen         (gen_if),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pkt_cnt   (o_pkt_cnt)
    );

    int          n_vec;
    int          n_err;
    int          busy_len;
    bit          gen_hold;
    int          done_total;
    logic [16:0] hdr_q[$];
    int          gap_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Header k (0-based) of a run, from the LFSR rules applied k times to the seed.
    function automatic logic [16:0] model_hdr(input bit m, input logic [3:0] d,
                                              input logic [2:0] p, input logic [9:0] l,
                                              input int k);
        int unsigned s;
        int unsigned rl;
        if (!m) return {d, p, l};
        s = SEED_V;
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (((s & 1) != 0) ? 32'hB400 : 32'h0);
        rl = ((s >> 8) & 32'hFF) * 4;
        if (rl < 64) rl = 64;
        return {s[3:0], s[6:4], rl[9:0]};
    endfunction

    // Generator model: busy for busy_len cycles after each accept; also logs headers,
    // ready-high/valid-low spacing between packets, and done pulses.
    initial begin : gen_model
        int busy_left;
        int gap_run;
        bit acc;
        busy_left = 0;
        gap_run   = 0;
        done_total = 0;
        gen_if.gen_ready = 1'b1;
        forever begin
            @(negedge clk);
            acc = rst_n && gen_if.gen_vld && gen_if.gen_ready;
            if (acc) hdr_q.push_back({gen_if.da, gen_if.prior, gen_if.len});
            if (o_done) done_total++;
            if (!o_busy) gap_run = 0;
            else if (gen_if.gen_vld) begin
                if (gap_run > 0) gap_q.push_back(gap_run);
                gap_run = 0;
            end else if (gen_if.gen_ready) gap_run++;
            @(posedge clk);
            #1;
            if (!rst_n) busy_left = 0;
            else if (acc) busy_left = busy_len;
            else if (busy_left > 0) busy_left--;
            gen_if.gen_ready = (busy_left == 0) && !gen_hold;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic set_cfg(input bit m, input logic [3:0] d, input logic [2:0] p,
                           input logic [9:0] l, input int num, input int gap);
        i_mode      = m;
        i_cfg_da    = d;
        i_cfg_prior = p;
        i_cfg_len   = l;
        i_cfg_num   = CNT_W'(num);
        i_cfg_gap   = GAP_W'(gap);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_done && n < 3000);
        check({tag, ":done_seen"}, o_done, 1);
    endtask

    task automatic wait_hdrs(input string tag, input int base, input int want);
        int n;
        n = 0;
        while (hdr_q.size() - base < want && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":hdr_wait"}, hdr_q.size() - base, want);
    endtask

    task automatic do_run(input bit m, input logic [3:0] d, input logic [2:0] p,
                          input logic [9:0] l, input int num, input int gap, input int blen,
                          input string tag);
        int hb;
        int gb;
        int db;
        logic [16:0] h;
        set_cfg(m, d, p, l, num, gap);
        busy_len = blen;
        hb = hdr_q.size();
        gb = gap_q.size();
        db = done_total;
        pulse_start();
        check({tag, ":cnt_clr"}, o_pkt_cnt, 0);
        check({tag, ":busy"}, o_busy, 1);
        // Mid-run config changes and a second start must have no effect.
        set_cfg(~m, 4'($urandom), 3'($urandom), 10'($urandom), 7, 9);
        pulse_start();
        wait_done(tag);
        tick();
        check({tag, ":idle"}, {o_busy, o_done, gen_if.gen_vld}, 0);
        check({tag, ":cnt"}, o_pkt_cnt, num);
        check({tag, ":done_cnt"}, done_total - db, 1);
        check({tag, ":n_hdr"}, hdr_q.size() - hb, num);
        for (int k = 0; k < num; k++) begin
            if (hb + k < hdr_q.size()) begin
                h = hdr_q[hb + k];
                check($sformatf("%s:hdr%0d", tag, k), h, model_hdr(m, d, p, l, k));
                if (m) check($sformatf("%s:len_ok%0d", tag, k),
                             (h[9:0] >= 10'd64) && (h[1:0] == 2'b00), 1);
            end
        end
        check({tag, ":n_gap"}, gap_q.size() - gb, num - 1);
        for (int k = gb; k < gap_q.size(); k++)
            check($sformatf("%s:gap%0d", tag, k - gb), gap_q[k], gap + 1);
    endtask

    initial begin : main
        int hb;
        int db;
        logic [3:0] rd;
        logic [2:0] rp;
        logic [9:0] rl;
        n_vec    = 0;
        n_err    = 0;
        busy_len = 1;
        gen_hold = 1'b0;
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_stop   = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {o_busy, o_done, gen_if.gen_vld}, 0);
        check("rst_cnt", o_pkt_cnt, 0);
        check("rst_hdr", {gen_if.da, gen_if.prior, gen_if.len}, 0);
        rst_n = 1'b1;
        tick();

        do_run(0, 4'd3, 3'd5, 10'd16, 2, 0, 3, "fixed");
        do_run(0, 4'hA, 3'd1, 10'd200, 3, 4, 2, "gap");
        do_run(1, 4'd0, 3'd0, 10'd0, 4, 1, 2, "rand1");
        do_run(1, 4'd0, 3'd0, 10'd0, 4, 1, 2, "rand2");

        // Backpressure: header held stable while the generator is not ready.
        set_cfg(0, 4'd9, 3'd2, 10'd100, 1, 0);
        busy_len = 2;
        gen_hold = 1'b1;
        tick();
        hb = hdr_q.size();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {gen_if.gen_vld, gen_if.da, gen_if.prior, gen_if.len},
                  {1'b1, 4'd9, 3'd2, 10'd100});
        end
        gen_hold = 1'b0;
        wait_done("bp");
        tick();
        check("bp_cnt", o_pkt_cnt, 1);
        check("bp_n_hdr", hdr_q.size() - hb, 1);

        // Stop during packet 3 of a continuous run: packet 3 still counts.
        set_cfg(0, 4'd5, 3'd3, 10'd40, 0, 2);
        busy_len = 12;
        hb = hdr_q.size();
        db = done_total;
        pulse_start();
        wait_hdrs("stop_pkt", hb, 3);
        repeat (3) @(negedge clk);
        tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        wait_done("stop_pkt");
        tick();
        check("stop_pkt_cnt", o_pkt_cnt, 3);
        check("stop_pkt_n_hdr", hdr_q.size() - hb, 3);
        check("stop_pkt_done", done_total - db, 1);
        check("stop_pkt_busy", o_busy, 0);

        // Stop while a header waits for accept: nothing issued, nothing counted.
        gen_hold = 1'b1;
        tick();
        hb = hdr_q.size();
        db = done_total;
        set_cfg(0, 4'd7, 3'd7, 10'd512, 0, 0);
        pulse_start();
        tick();
        tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        wait_done("stop_issue");
        tick();
        check("stop_issue_cnt", o_pkt_cnt, 0);
        check("stop_issue_n_hdr", hdr_q.size() - hb, 0);
        check("stop_issue_done", done_total - db, 1);
        check("stop_issue_vld", gen_if.gen_vld, 0);
        gen_hold = 1'b0;
        tick();

        // Asynchronous reset while waiting for packet completion.
        set_cfg(0, 4'd1, 3'd1, 10'd80, 0, 0);
        busy_len = 20;
        hb = hdr_q.size();
        pulse_start();
        wait_hdrs("rst_mid", hb, 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ctl", {o_busy, o_done, gen_if.gen_vld}, 0);
        check("rst_mid_cnt", o_pkt_cnt, 0);
        check("rst_mid_hdr", {gen_if.da, gen_if.prior, gen_if.len}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        do_run(1, 4'd0, 3'd0, 10'd0, 2, 0, 1, "after_rst");

        for (int r = 0; r < 8; r++) begin
            rd = 4'($urandom);
            rp = 3'($urandom);
            rl = 10'($urandom);
            do_run(1'($urandom_range(0, 1)), rd, rp, rl, int'($urandom_range(1, 5)),
                   int'($urandom_range(0, 6)), int'($urandom_range(1, 6)),
                   $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
